// File: rtl/md_ctrl_pkg.sv
// Shared types and constants for the mult/div stall controller.
// MD_MAX_CYCLES/MD_CNT_W size the watchdog built under MD_TIMEOUT_EN.
package md_ctrl_pkg;

    localparam int unsigned MD_MAX_CYCLES = 40;
    localparam int unsigned MD_CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } mdState_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } mdOp_e;

endpackage

// File: rtl/md_stall_ctrl_if.sv
// Pipeline-side handshake between the X-stage mult/div controller and its
// neighbours. The master modport is the controller.
interface md_stall_ctrl_if;

    logic dx_op_mult;
    logic dx_op_div;
    logic flush;
    logic md_result_rdy;
    logic md_exception;
    logic ctrl_mult;
    logic ctrl_div;
    logic fd_en;
    logic dx_en;
    logic xm_bubble;
    logic md_wb_valid;
    logic md_ovf;
    logic busy;

    modport master (
        input  dx_op_mult, dx_op_div, flush, md_result_rdy, md_exception,
        output ctrl_mult, ctrl_div, fd_en, dx_en, xm_bubble, md_wb_valid,
               md_ovf, busy
    );

    modport slave (
        output dx_op_mult, dx_op_div, flush, md_result_rdy, md_exception,
        input  ctrl_mult, ctrl_div, fd_en, dx_en, xm_bubble, md_wb_valid,
               md_ovf, busy
    );

endinterface

// File: rtl/md_watchdog.sv
// BUSY-cycle watchdog for the mult/div controller: clears on START, counts
// BUSY cycles and flags the terminal count. Used only under MD_TIMEOUT_EN.
module md_watchdog
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = MD_MAX_CYCLES,
    parameter int unsigned CNT_W      = MD_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Last BUSY cycle is the one holding MAX_CYCLES-1.
    assign expired_c = enable && (cnt == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/md_stall_ctrl.sv
// Mult/div sequencer: start pulse, pipeline stall/bubble while the unit runs,
// writeback strobe on completion. Define MD_TIMEOUT_EN for the BUSY watchdog.
module md_stall_ctrl
    import md_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    md_stall_ctrl_if.master md
);

    mdState_e state;
    mdState_e stateNext;
    mdOp_e    opReg;
    mdOp_e    opNext;
    logic     ovfReg;
    logic     ovfNext;
    logic     go;
    logic     timeout;
    logic     pipeEn;
    logic     bubble;
    logic     startMult;
    logic     startDiv;
    logic     wbValid;
    logic     ovfOut;

    // A flushed DX instruction must never start the unit.
    assign go = (md.dx_op_mult | md.dx_op_div) & ~md.flush;

`ifdef MD_TIMEOUT_EN
    md_watchdog #(
        .MAX_CYCLES (MD_MAX_CYCLES),
        .CNT_W      (MD_CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state == START),
        .enable    (state == BUSY),
        .expired_c (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            opReg  <= OP_MULT;
            ovfReg <= 1'b0;
        end else begin
            state  <= stateNext;
            opReg  <= opNext;
            ovfReg <= ovfNext;
        end
    end

    always_comb begin
        stateNext = state;
        opNext    = opReg;
        ovfNext   = ovfReg;
        pipeEn    = 1'b1;
        bubble    = 1'b0;
        startMult = 1'b0;
        startDiv  = 1'b0;
        wbValid   = 1'b0;
        ovfOut    = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) begin
                    pipeEn    = 1'b0;
                    bubble    = 1'b1;
                    opNext    = md.dx_op_mult ? OP_MULT : OP_DIV;
                    stateNext = START;
                end
            end
            START: begin
                // Any rdy seen here belongs to a previous operation.
                pipeEn    = 1'b0;
                bubble    = 1'b1;
                startMult = (opReg == OP_MULT);
                startDiv  = (opReg == OP_DIV);
                stateNext = BUSY;
            end
            BUSY: begin
                pipeEn = 1'b0;
                bubble = 1'b1;
                if (md.md_result_rdy) begin
                    ovfNext   = md.md_exception;
                    stateNext = DONE;
                end else if (timeout) begin
                    ovfNext   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                wbValid   = 1'b1;
                ovfOut    = ovfReg;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign md.ctrl_mult   = startMult;
    assign md.ctrl_div    = startDiv;
    assign md.fd_en       = pipeEn;
    assign md.dx_en       = pipeEn;
    assign md.xm_bubble   = bubble;
    assign md.md_wb_valid = wbValid;
    assign md.md_ovf      = ovfOut;
    assign md.busy        = (state != IDLE);

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Scoreboard bench for md_stall_ctrl: expected start op and writeback overflow
// are queued at issue and checked by a monitor when the DUT produces them.
module tb_md_stall_ctrl;
    import md_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    md_stall_ctrl_if mdIf ();

    md_stall_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mdIf)
    );

    int total = 0;
    int bad   = 0;
    bit opQ[$];
    bit resQ[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit stallSeen();
        return (mdIf.fd_en == 1'b0) && (mdIf.dx_en == 1'b0) && (mdIf.xm_bubble == 1'b1);
    endfunction

    task automatic chkReset(input string tag);
        chk({tag, "_busy"}, 32'(mdIf.busy), 0);
        chk({tag, "_fd_en"}, 32'(mdIf.fd_en), 1);
        chk({tag, "_dx_en"}, 32'(mdIf.dx_en), 1);
        chk({tag, "_bubble"}, 32'(mdIf.xm_bubble), 0);
        chk({tag, "_pulse"}, 32'({mdIf.ctrl_mult, mdIf.ctrl_div}), 0);
        chk({tag, "_wb"}, 32'(mdIf.md_wb_valid), 0);
        chk({tag, "_ovf"}, 32'(mdIf.md_ovf), 0);
    endtask

    // Monitor: start pulses and writeback strobes are matched against the queues.
    always @(negedge clk) begin
        bit expOp;
        bit expOvf;
        if (reset_n) begin
            if (mdIf.ctrl_mult || mdIf.ctrl_div) begin
                if (opQ.size() == 0) begin
                    chk("pulse_unexpected", 32'({mdIf.ctrl_mult, mdIf.ctrl_div}), 0);
                end else begin
                    expOp = opQ.pop_front();
                    chk("pulse_op", 32'({mdIf.ctrl_mult, mdIf.ctrl_div}), expOp ? 32'd2 : 32'd1);
                end
            end
            if (mdIf.md_wb_valid) begin
                if (resQ.size() == 0) begin
                    chk("wb_unexpected", 32'(mdIf.md_wb_valid), 0);
                end else begin
                    expOvf = resQ.pop_front();
                    chk("wb_ovf", 32'(mdIf.md_ovf), 32'(expOvf));
                end
            end else begin
                chk("ovf_quiet", 32'(mdIf.md_ovf), 0);
            end
        end
    end

    // One full operation: issue in IDLE, rdy 'delay' cycles after the pulse.
    task automatic runOp(input bit isMult, input int delay, input bit exc, input bit rdyInStart);
        int stalls = 0;
        cyc();
        mdIf.dx_op_mult = isMult;
        mdIf.dx_op_div  = ~isMult;
        opQ.push_back(isMult);
        resQ.push_back(exc);
        @(negedge clk);
        if (stallSeen()) stalls++;
        cyc();
        mdIf.dx_op_mult    = 1'b0;
        mdIf.dx_op_div     = 1'b0;
        mdIf.md_result_rdy = rdyInStart;
        mdIf.md_exception  = rdyInStart;
        @(negedge clk);
        if (stallSeen()) stalls++;
        chk("start_busy", 32'(mdIf.busy), 1);
        for (int i = 1; i <= delay; i++) begin
            cyc();
            mdIf.md_result_rdy = (i == delay);
            mdIf.md_exception  = (i == delay) && exc;
            @(negedge clk);
            if (stallSeen()) stalls++;
        end
        cyc();
        mdIf.md_result_rdy = 1'b0;
        mdIf.md_exception  = 1'b0;
        @(negedge clk);
        chk("done_wb", 32'(mdIf.md_wb_valid), 1);
        chk("done_fd_en", 32'(mdIf.fd_en), 1);
        chk("done_dx_en", 32'(mdIf.dx_en), 1);
        chk("done_bubble", 32'(mdIf.xm_bubble), 0);
        chk("stall_cycles", 32'(stalls), 32'(delay + 2));
    endtask

    task automatic pulseReset();
        #2;
        reset_n = 1'b0;
        #1;
        chkReset("rst_async");
        resQ.delete();
        opQ.delete();
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        int hung;
        mdIf.dx_op_mult    = 1'b0;
        mdIf.dx_op_div     = 1'b0;
        mdIf.flush         = 1'b0;
        mdIf.md_result_rdy = 1'b0;
        mdIf.md_exception  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkReset("rst_init");
        reset_n = 1'b1;

        // Mult, rdy 17 cycles after pulse: 19 stall cycles.
        runOp(1'b1, 17, 1'b0, 1'b0);
        // Back-to-back div with exception.
        runOp(1'b0, 5, 1'b1, 1'b0);
        cyc();
        @(negedge clk);
        chk("idle_after_done", 32'(mdIf.busy), 0);

        // Flush wins over a mult in DX.
        cyc();
        mdIf.dx_op_mult = 1'b1;
        mdIf.flush      = 1'b1;
        @(negedge clk);
        chk("flush_fd_en", 32'(mdIf.fd_en), 1);
        chk("flush_bubble", 32'(mdIf.xm_bubble), 0);
        cyc();
        mdIf.dx_op_mult = 1'b0;
        mdIf.flush      = 1'b0;
        @(negedge clk);
        chk("flush_no_busy", 32'(mdIf.busy), 0);

        // Stale rdy during START is ignored.
        runOp(1'b1, 6, 1'b0, 1'b1);

        // Async reset mid-BUSY, then restart.
        cyc();
        mdIf.dx_op_mult = 1'b1;
        opQ.push_back(1'b1);
        cyc();
        mdIf.dx_op_mult = 1'b0;
        repeat (4) cyc();
        pulseReset();
        runOp(1'b1, 3, 1'b1, 1'b0);

        // No rdy at all.
        cyc();
        mdIf.dx_op_div = 1'b1;
        opQ.push_back(1'b0);
`ifdef MD_TIMEOUT_EN
        resQ.push_back(1'b1);
`endif
        cyc();
        mdIf.dx_op_div = 1'b0;
`ifdef MD_TIMEOUT_EN
        hung = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            @(negedge clk);
            if (mdIf.md_wb_valid || !mdIf.busy) hung++;
        end
        chk("timeout_early", 32'(hung), 0);
        cyc();
        @(negedge clk);
        chk("timeout_wb", 32'(mdIf.md_wb_valid), 1);
        // rdy on the terminal-count cycle is a normal completion.
        runOp(1'b1, 40, 1'b0, 1'b0);
`else
        hung = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            @(negedge clk);
            if (mdIf.busy && !mdIf.md_wb_valid) hung++;
        end
        chk("no_timeout_busy", 32'(hung), 100);
        cyc();
        pulseReset();
        runOp(1'b0, 2, 1'b0, 1'b0);
`endif

        cyc();
        @(negedge clk);
        chk("end_idle", 32'(mdIf.busy), 0);
        chk("op_q_empty", 32'(opQ.size()), 0);
        chk("res_q_empty", 32'(resQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
